// File: rtl/r_type_program_loader.sv
// r_type_program_loader: packs R-type field tuples into 32-bit RISC-V words
// and writes them to instruction memory at sequential word addresses from
// BASE_ADDR, one word per two cycles.
// Optional build macro: FILL_NOP_EN -- pad the rest of the session with
// NOP (addi x0,x0,0) writes after the last tuple until DEPTH words exist.
module r_type_program_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    DEPTH      = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [6:0]                   func7,
  input  logic [4:0]                   rs2,
  input  logic [4:0]                   rs1,
  input  logic [2:0]                   func3,
  input  logic [4:0]                   rd,
  output logic                         mem_write_enable,
  output logic [ADDR_WIDTH-1:0]        mem_address,
  output logic [31:0]                  mem_write_data,
  output logic [$clog2(DEPTH+1)-1:0]   word_count,
  output logic                         busy,
  output logic                         done
);
  localparam int          CW   = $clog2(DEPTH+1);
  localparam logic [6:0]  OP_R = 7'b0110011;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct packed {
    logic [6:0] func7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
  } r_fields_t;

`ifdef FILL_NOP_EN
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_FILL, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;
`endif

  state_t          state, state_nxt;
  logic            last_q;
  logic [CW-1:0]   wc_inc;
  logic            at_full;
  logic            take_start;
  logic            take_tuple;
  r_fields_t       fields;

  assign fields     = '{func7: func7, rs2: rs2, rs1: rs1, func3: func3, rd: rd};
  assign wc_inc     = word_count + CW'(1);
  assign at_full    = (wc_inc == CW'(DEPTH));
  assign take_start = start && (state == S_IDLE || state == S_DONE);
  assign take_tuple = in_valid && in_ready;

  // state register; async reset aborts any session in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state: a write always follows an accept; full depth ends the session
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_ACCEPT;
      S_ACCEPT:       if (in_valid) state_nxt = S_WRITE;
      S_WRITE: begin
        if (at_full)     state_nxt = S_DONE;
`ifdef FILL_NOP_EN
        else if (last_q) state_nxt = S_FILL;
`else
        else if (last_q) state_nxt = S_DONE;
`endif
        else             state_nxt = S_ACCEPT;
      end
`ifdef FILL_NOP_EN
      S_FILL:         if (at_full) state_nxt = S_DONE;
`endif
      default:        state_nxt = S_IDLE;
    endcase
  end

  // decoded outputs; all derive from state so reset clears them at once
  always_comb begin
    in_ready         = 1'b0;
    mem_write_enable = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    case (state)
      S_ACCEPT: begin in_ready = 1'b1; busy = 1'b1; end
      S_WRITE:  begin mem_write_enable = 1'b1; busy = 1'b1; end
`ifdef FILL_NOP_EN
      S_FILL:   begin mem_write_enable = 1'b1; busy = 1'b1; end
`endif
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  // datapath: word register, address pointer and counter; the address only
  // advances when another write follows, so it rests on the last one written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_address    <= BASE_ADDR;
      mem_write_data <= '0;
      word_count     <= '0;
      last_q         <= 1'b0;
    end else if (take_start) begin
      mem_address <= BASE_ADDR;
      word_count  <= '0;
    end else if (take_tuple) begin
      mem_write_data <= {fields, OP_R};
      last_q         <= in_last;
    end else if (mem_write_enable) begin
      word_count <= wc_inc;
      if (state_nxt != S_DONE) mem_address <= mem_address + ADDR_WIDTH'(4);
`ifdef FILL_NOP_EN
      if (state_nxt == S_FILL) mem_write_data <= NOP;
`endif
    end
  end

`ifndef FILL_NOP_EN
  logic unused_nop;
  assign unused_nop = ^NOP;
`endif

endmodule

// File: tb/tb_r_type_program_loader.sv
// Directed bench for r_type_program_loader (DEPTH=4, BASE_ADDR=0).
// Expectations follow FILL_NOP_EN when the bench is built with it.
module tb_r_type_program_loader;
  logic        clock = 1'b0;
  logic        reset;
  logic        start, in_valid, in_last, in_ready;
  logic [6:0]  func7;
  logic [4:0]  rs2, rs1, rd;
  logic [2:0]  func3;
  logic        mem_write_enable, busy, done;
  logic [31:0] mem_address, mem_write_data;
  logic [2:0]  word_count;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  r_type_program_loader #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .func7(func7), .rs2(rs2),
    .rs1(rs1), .func3(func3), .rd(rd), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .word_count(word_count), .busy(busy), .done(done));

  always #5 clock = ~clock;

  // record every write strobe mid-cycle
  always @(negedge clock)
    if (reset && mem_write_enable) begin
      log_a.push_back(mem_address);
      log_d.push_back(mem_write_data);
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobe(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < log_a.size()) begin
      chk({tag, "_addr"}, log_a[idx], a);
      chk({tag, "_data"}, log_d[idx], d);
    end else
      chk({tag, "_missing"}, 32'(log_a.size()), 32'(idx + 1));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                      input logic [2:0] f3, input logic [4:0] d, input logic last);
    int k = 0;
    func7 = f7; rs2 = s2; rs1 = s1; func3 = f3; rd = d; in_last = last;
    in_valid = 1'b1;
    while (!in_ready && k < 20) begin @(negedge clock); k++; end
    if (k >= 20) chk("send_timeout", {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 50) begin @(negedge clock); k++; end
    chk("done", {31'b0, done}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_we"},    {31'b0, mem_write_enable}, 32'd0);
    chk({tag, "_addr"},  mem_address, 32'h0);
    chk({tag, "_data"},  mem_write_data, 32'h0);
    chk({tag, "_count"}, {29'b0, word_count}, 32'd0);
    chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
    chk({tag, "_done"},  {31'b0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    func7 = '0; rs2 = '0; rs1 = '0; func3 = '0; rd = '0;
    #12;
    chk_reset_vals("rst");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // 1 / 6: add x3,x1,x2 as the only (last) tuple
    log_a.delete(); log_d.delete();
    do_start();
    chk("t1_busy", {31'b0, busy}, 32'd1);
    chk("t1_ready", {31'b0, in_ready}, 32'd1);
    send(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 1'b1);
    wait_done();
    chk("t1_busy_done", {31'b0, busy}, 32'd0);
    chk_strobe("t1_w0", 0, 32'h0, 32'h002081B3);
`ifdef FILL_NOP_EN
    chk_strobe("t6_f1", 1, 32'h4, 32'h00000013);
    chk_strobe("t6_f2", 2, 32'h8, 32'h00000013);
    chk_strobe("t6_f3", 3, 32'hC, 32'h00000013);
    chk("t6_nstrobe", 32'(log_a.size()), 32'd4);
    chk("t6_count", {29'b0, word_count}, 32'd4);
    chk("t6_hold", mem_write_data, 32'h00000013);
`else
    chk("t1_nstrobe", 32'(log_a.size()), 32'd1);
    chk("t1_count", {29'b0, word_count}, 32'd1);
    chk("t1_hold", mem_write_data, 32'h002081B3);
`endif

    // 2: sub then add(last); a start pulse mid-session is ignored
    log_a.delete(); log_d.delete();
    do_start();
    chk("t2_count0", {29'b0, word_count}, 32'd0);
    chk("t2_done0", {31'b0, done}, 32'd0);
    send(7'h20, 5'd7, 5'd6, 3'd0, 5'd5, 1'b0);
    @(negedge clock);
    do_start();
    send(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 1'b1);
    wait_done();
    chk_strobe("t2_w0", 0, 32'h0, 32'h407302B3);
    chk_strobe("t2_w1", 1, 32'h4, 32'h002081B3);
`ifdef FILL_NOP_EN
    chk_strobe("t2_f2", 2, 32'h8, 32'h00000013);
    chk_strobe("t2_f3", 3, 32'hC, 32'h00000013);
    chk("t2_count", {29'b0, word_count}, 32'd4);
`else
    chk("t2_nstrobe", 32'(log_a.size()), 32'd2);
    chk("t2_count", {29'b0, word_count}, 32'd2);
`endif

    // 3: no in_last; session ends at DEPTH=4, fifth tuple not consumed
    log_a.delete(); log_d.delete();
    do_start();
    send(7'h20, 5'd7, 5'd6, 3'd0, 5'd5, 1'b0);
    send(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 1'b0);
    send(7'h00, 5'd1, 5'd1, 3'd0, 5'd1, 1'b0);
    send(7'h00, 5'd2, 5'd2, 3'd0, 5'd2, 1'b0);
    wait_done();
    chk_strobe("t3_w0", 0, 32'h0, 32'h407302B3);
    chk_strobe("t3_w1", 1, 32'h4, 32'h002081B3);
    chk_strobe("t3_w2", 2, 32'h8, 32'h001080B3);
    chk_strobe("t3_w3", 3, 32'hC, 32'h00210133);
    chk("t3_count", {29'b0, word_count}, 32'd4);
    func7 = 7'h7F; rs2 = 5'd31; rs1 = 5'd31; func3 = 3'd7; rd = 5'd31; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t3_ready_off", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    chk("t3_nstrobe", 32'(log_a.size()), 32'd4);
    chk("t3_count_hold", {29'b0, word_count}, 32'd4);

    // 4: in_valid held high; ready toggles, one write per two cycles
    log_a.delete(); log_d.delete();
    do_start();
    func7 = 7'h00; rs2 = 5'd2; rs1 = 5'd1; func3 = 3'd0; rd = 5'd3; in_last = 1'b0;
    in_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("t4_ready", {31'b0, in_ready}, {31'b0, (j % 2 == 0)});
      chk("t4_we", {31'b0, mem_write_enable}, {31'b0, (j % 2 == 1)});
      if (j == 1) begin func7 = 7'h20; rs2 = 5'd7; rs1 = 5'd6; rd = 5'd5; end
      if (j == 3) begin func7 = 7'h00; rs2 = 5'd2; rs1 = 5'd2; rd = 5'd2; in_last = 1'b1; end
      @(negedge clock);
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_done();
    chk_strobe("t4_w0", 0, 32'h0, 32'h002081B3);
    chk_strobe("t4_w1", 1, 32'h4, 32'h407302B3);
    chk_strobe("t4_w2", 2, 32'h8, 32'h00210133);
`ifdef FILL_NOP_EN
    chk("t4_nstrobe", 32'(log_a.size()), 32'd4);
`else
    chk("t4_nstrobe", 32'(log_a.size()), 32'd3);
`endif

    // 5: reset asserted during the second word's write cycle
    do_start();
    send(7'h20, 5'd7, 5'd6, 3'd0, 5'd5, 1'b0);
    send(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 1'b0);
    chk("t5_we_pre", {31'b0, mem_write_enable}, 32'd1);
    chk("t5_addr_pre", mem_address, 32'h4);
    #2 reset = 1'b0;
    #1 chk_reset_vals("t5_abort");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    log_a.delete(); log_d.delete();
    do_start();
    send(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 1'b1);
    wait_done();
    chk_strobe("t5_w0", 0, 32'h0, 32'h002081B3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
